// File: rtl/frame_buffer_if.sv
// Host write channel of the frame buffer: valid/ready handshake carrying one pixel write.
interface frame_buffer_if #(
   parameter int ADDR_W = 14
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/frame_buffer.sv
// One-bit-per-pixel frame buffer: free-running 2-cycle display read port, host
// write port with valid/ready, and a whole-buffer fill engine.
module frame_buffer #(
   parameter int ADDR_W = 14
) (
   input  logic              vga_clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_data,
   frame_buffer_if.slave     wr,
   input  logic              fill_start,
   input  logic              fill_value,
   output logic              busy,
   output logic              fill_done
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_FILL = 1'b1;

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_fill_val;
   logic              r_fill_done;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_rd_data;
   logic              r_mem [0:DEPTH-1];

   logic              w_wr_ready;
   logic              w_filling;
   logic              w_last;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic              w_wdata;

   assign w_filling  = (r_state == S_FILL);
   assign w_last     = (r_cnt == '1);
   assign w_wr_ready = (r_state == S_IDLE) && !fill_start;

   // The fill engine owns the single write port while busy; host writes only in IDLE.
   assign w_we    = w_filling || (wr.wr_valid && w_wr_ready);
   assign w_waddr = w_filling ? r_cnt : wr.wr_addr;
   assign w_wdata = w_filling ? r_fill_val : wr.wr_data;

   assign wr.wr_ready = w_wr_ready;
   assign busy        = w_filling;
   assign fill_done   = r_fill_done;
   assign rd_data     = r_rd_data;

   // Storage is deliberately not reset: an aborted fill must leave unwritten words intact.
   always_ff @(posedge vga_clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   always_ff @(posedge vga_clk or negedge rst) begin
      if (!rst) begin
         r_rd_addr <= '0;
         r_rd_data <= 1'b0;
      end else begin
         r_rd_addr <= rd_addr;
         r_rd_data <= r_mem[r_rd_addr];
      end
   end

   always_ff @(posedge vga_clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_fill_val  <= 1'b0;
         r_fill_done <= 1'b0;
      end else begin
         r_fill_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (fill_start) begin
                  r_fill_val <= fill_value;
                  r_cnt      <= '0;
                  r_state    <= S_FILL;
               end
            end
            S_FILL: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state     <= S_IDLE;
                  r_fill_done <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_frame_buffer.sv
// Self-checking bench for frame_buffer: scenario tasks checked against a flat
// array model of pixel contents.
module tb_frame_buffer;
   localparam int AW = 14;
   localparam int N  = 1 << AW;

   logic          vga_clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rd_addr;
   logic          rd_data;
   logic          fill_start;
   logic          fill_value;
   logic          busy;
   logic          fill_done;

   frame_buffer_if #(.ADDR_W(AW)) wif ();

   frame_buffer #(.ADDR_W(AW)) dut (
      .vga_clk   (vga_clk),
      .rst       (rst),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .wr        (wif.slave),
      .fill_start(fill_start),
      .fill_value(fill_value),
      .busy      (busy),
      .fill_done (fill_done)
   );

   always #5 vga_clk = ~vga_clk;

   bit model [N];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; rd_addr = '0; fill_start = 1'b0; fill_value = 1'b0;
      wif.wr_valid = 1'b0; wif.wr_addr = '0; wif.wr_data = 1'b0;
      repeat (3) tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_tests++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", fill_done); end
      n_tests++; if (rd_data !== 1'b0) begin n_fail++; $display("FAIL reset_rd_data: got %b expected 0", rd_data); end
      rst = 1'b1;
      tick();
      n_tests++; if (wif.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 1", wif.wr_ready); end
   endtask

   task automatic test_fill();
      int cyc = 0; int dones = 0; int ready_bad = 0; int bad = 0;
      fill_value = 1'b1; fill_start = 1'b1;
      #1;
      n_tests++; if (wif.wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_start_ready: got %b expected 0", wif.wr_ready); end
      tick();
      fill_start = 1'b0; fill_value = 1'b0;
      while (busy === 1'b1 && cyc < N + 100) begin
         if (wif.wr_ready !== 1'b0) ready_bad++;
         if (fill_done === 1'b1) dones++;
         cyc++;
         tick();
      end
      n_tests++; if (cyc != N) begin n_fail++; $display("FAIL fill_busy_len: got %0d expected %0d", cyc, N); end
      n_tests++; if (ready_bad != 0) begin n_fail++; $display("FAIL fill_ready_low: got %0d high cycles expected 0", ready_bad); end
      n_tests++; if (dones != 0) begin n_fail++; $display("FAIL fill_done_early: got %0d pulses expected 0", dones); end
      n_tests++; if (fill_done !== 1'b1) begin n_fail++; $display("FAIL fill_done_pulse: got %b expected 1", fill_done); end
      tick();
      n_tests++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL fill_done_width: got %b expected 0", fill_done); end
      for (int a = 0; a < N; a++) model[a] = 1'b1;
      for (int i = 0; i <= N; i++) begin
         if (i < N) rd_addr = AW'(i);
         tick();
         if (i >= 1 && rd_data !== model[i-1]) begin
            if (bad == 0) $display("FAIL fill_sweep: addr %0d got %b expected %b", i - 1, rd_data, model[i-1]);
            bad++;
         end
      end
      n_tests++; if (bad != 0) n_fail++;
   endtask

   task automatic test_conflict_restart();
      int unsigned x; int unsigned addrs[$];
      int cyc = 0; int ready_bad = 0; int bad = 0;
      x = $urandom_range(0, N - 1);
      wif.wr_valid = 1'b1; wif.wr_addr = AW'(x); wif.wr_data = 1'b1;
      fill_value = 1'b0; fill_start = 1'b1;
      #1;
      n_tests++; if (wif.wr_ready !== 1'b0) begin n_fail++; $display("FAIL conflict_ready: got %b expected 0", wif.wr_ready); end
      tick();
      while (busy === 1'b1 && cyc < N + 100) begin
         if (wif.wr_ready !== 1'b0) ready_bad++;
         fill_start = (cyc == 5000);
         fill_value = (cyc == 5000);
         cyc++;
         tick();
      end
      fill_start = 1'b0; fill_value = 1'b0;
      n_tests++; if (cyc != N) begin n_fail++; $display("FAIL restart_busy_len: got %0d expected %0d", cyc, N); end
      n_tests++; if (ready_bad != 0) begin n_fail++; $display("FAIL conflict_ready_low: got %0d high cycles expected 0", ready_bad); end
      n_tests++; if (fill_done !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b expected 1", fill_done); end
      n_tests++; if (wif.wr_ready !== 1'b1) begin n_fail++; $display("FAIL held_write_ready: got %b expected 1", wif.wr_ready); end
      tick();
      wif.wr_valid = 1'b0;
      for (int a = 0; a < N; a++) model[a] = 1'b0;
      model[x] = 1'b1;
      addrs.push_back(x);
      addrs.push_back((x + 1) % N);
      addrs.push_back(0);
      addrs.push_back(N - 1);
      repeat (1000) addrs.push_back($urandom_range(0, N - 1));
      for (int i = 0; i <= addrs.size(); i++) begin
         if (i < addrs.size()) rd_addr = AW'(addrs[i]);
         tick();
         if (i >= 1 && rd_data !== model[addrs[i-1]]) begin
            if (bad == 0) $display("FAIL restart_sweep: addr %0d got %b expected %b", addrs[i-1], rd_data, model[addrs[i-1]]);
            bad++;
         end
      end
      n_tests++; if (bad != 0) n_fail++;
   endtask

   task automatic test_write_read();
      int unsigned a  = 32'h2200;
      int unsigned nb = 32'h2201;
      rd_addr = AW'(nb);
      tick(); tick();
      wif.wr_valid = 1'b1; wif.wr_addr = AW'(a); wif.wr_data = 1'b1;
      #1;
      n_tests++; if (wif.wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_idle: got %b expected 1", wif.wr_ready); end
      tick();
      wif.wr_valid = 1'b0;
      model[a] = 1'b1;
      rd_addr = AW'(a);
      tick();
      n_tests++; if (rd_data !== model[nb]) begin n_fail++; $display("FAIL read_latency_1: got %b expected %b", rd_data, model[nb]); end
      tick();
      n_tests++; if (rd_data !== 1'b1) begin n_fail++; $display("FAIL read_latency_2: got %b expected 1", rd_data); end
      rd_addr = AW'(nb);
      tick(); tick();
      n_tests++; if (rd_data !== model[nb]) begin n_fail++; $display("FAIL neighbour_read: got %b expected %b", rd_data, model[nb]); end
   endtask

   task automatic test_read_before_write();
      int unsigned a;
      a = $urandom_range(0, N - 1);
      wif.wr_valid = 1'b1; wif.wr_addr = AW'(a); wif.wr_data = 1'b0;
      tick();
      model[a] = 1'b0;
      wif.wr_valid = 1'b0;
      rd_addr = AW'(a);
      tick();
      wif.wr_valid = 1'b1; wif.wr_data = 1'b1;
      tick();
      n_tests++; if (rd_data !== 1'b0) begin n_fail++; $display("FAIL rbw_old: got %b expected 0", rd_data); end
      wif.wr_valid = 1'b0;
      model[a] = 1'b1;
      tick();
      n_tests++; if (rd_data !== 1'b1) begin n_fail++; $display("FAIL rbw_new: got %b expected 1", rd_data); end
   endtask

   task automatic test_random_traffic();
      int unsigned base = N - 8;
      int unsigned prev_ra = 0;
      int unsigned ra, wa;
      bit v, d, exp_bit;
      for (int i = 0; i < 400; i++) begin
         v  = 1'($urandom_range(0, 1));
         d  = 1'($urandom_range(0, 1));
         wa = (base + $urandom_range(0, 15)) % N;
         ra = (base + $urandom_range(0, 15)) % N;
         wif.wr_valid = v; wif.wr_addr = AW'(wa); wif.wr_data = d;
         rd_addr = AW'(ra);
         #1;
         n_tests++; if (wif.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rand_ready: cycle %0d got %b expected 1", i, wif.wr_ready); end
         tick();
         exp_bit = model[prev_ra];
         if (v) model[wa] = d;
         if (i > 0) begin
            n_tests++;
            if (rd_data !== exp_bit) begin n_fail++; $display("FAIL rand_read: cycle %0d addr %0d got %b expected %b", i, prev_ra, rd_data, exp_bit); end
         end
         prev_ra = ra;
      end
      wif.wr_valid = 1'b0;
   endtask

   task automatic test_reset_midfill();
      int unsigned addrs[$];
      int dones = 0; int bad = 0;
      fill_value = 1'b1; fill_start = 1'b1;
      tick();
      fill_start = 1'b0;
      repeat (100) tick();
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midfill_busy: got %b expected 1", busy); end
      rst = 1'b0;
      #1;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
      repeat (3) begin tick(); if (fill_done === 1'b1) dones++; end
      rst = 1'b1;
      repeat (5) begin tick(); if (fill_done === 1'b1 || busy === 1'b1) dones++; end
      n_tests++; if (dones != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", dones); end
      n_tests++; if (wif.wr_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", wif.wr_ready); end
      for (int a = 0; a < 99; a++) model[a] = 1'b1;
      for (int a = 0; a < 300; a++) if (a != 99) addrs.push_back(a);
      repeat (500) addrs.push_back($urandom_range(100, N - 1));
      for (int i = 0; i <= addrs.size(); i++) begin
         if (i < addrs.size()) rd_addr = AW'(addrs[i]);
         tick();
         if (i >= 1 && rd_data !== model[addrs[i-1]]) begin
            if (bad == 0) $display("FAIL abort_sweep: addr %0d got %b expected %b", addrs[i-1], rd_data, model[addrs[i-1]]);
            bad++;
         end
      end
      n_tests++; if (bad != 0) n_fail++;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_conflict_restart();
      test_write_read();
      test_read_before_write();
      test_random_traffic();
      test_reset_midfill();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/frame_buffer.md
FRAME_BUFFER -- requirements
Module: frame_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, address width; depth is 2^ADDR_W one-bit pixels.
REQ-002 SHALL have port vga_clk  input  1  pixel clock; the single clock for all logic.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rd_addr  input  ADDR_W  display read address, driven by the VGA controller.
REQ-005 SHALL have port rd_data  output  1  pixel bit for rd_addr, registered.
REQ-006 SHALL have port wr_valid  input  1  host write request.
REQ-007 SHALL have port wr_ready  output  1  write accept; a write transfers when wr_valid and wr_ready are both high on a rising edge.
REQ-008 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-009 SHALL have port wr_data  input  1  write pixel value.
REQ-010 SHALL have port fill_start  input  1  single-cycle request to fill the whole buffer.
REQ-011 SHALL have port fill_value  input  1  fill pixel value, sampled with fill_start.
REQ-012 SHALL have port busy  output  1  high while a fill is in progress.
REQ-013 SHALL have port fill_done  output  1  one-cycle pulse at fill completion.

Function
REQ-014 SHALL store 2^ADDR_W one-bit words in a single synchronous-write memory with one read port and one write port.
REQ-015 Read latency SHALL be exactly 2 cycles: rd_addr is registered at edge N, memory is read at edge N+1, rd_data is valid after edge N+1 and holds until the next update; this matches the controller's 2-stage sync delay.
REQ-016 The read port SHALL never stall; it is unaffected by writes or fills.
REQ-017 A same-address read and write on the same edge SHALL return the old data (read-before-write).
REQ-018 The FSM SHALL have two states, IDLE and FILL.
REQ-019 In IDLE: wr_ready = !fill_start (combinational); an accepted write stores wr_data at wr_addr on that edge.
REQ-020 In IDLE with fill_start high: SHALL latch fill_value, clear fill counter to 0, enter FILL; any concurrent wr_valid SHALL NOT be accepted.
REQ-021 In FILL: wr_ready = 0; busy = 1; each cycle SHALL write the latched fill value at the counter address and increment the counter by 1.
REQ-022 When the counter reaches 2^ADDR_W-1, that edge SHALL write the last word and enter IDLE; the counter SHALL NOT wrap into a second pass.
REQ-023 busy SHALL be high for exactly 2^ADDR_W cycles, starting the cycle after fill_start is sampled.
REQ-024 fill_done SHALL be a registered pulse that is high for exactly the one cycle after the final fill write, coincident with busy falling.
REQ-025 fill_start while in FILL SHALL be ignored; the fill SHALL NOT be restarted and its value SHALL NOT change.
REQ-026 wr_valid held high while wr_ready is low SHALL be held by the host; the write is accepted on the first edge with wr_ready high.
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_W; there are no out-of-range addresses.

Reset
REQ-028 While rst is low: state IDLE, fill counter 0, rd_data 0, busy 0, fill_done 0, read address register 0.
REQ-029 wr_ready SHALL be 1 from the first cycle after rst deasserts, provided fill_start is low.
REQ-030 Memory contents SHALL NOT be reset; reset during FILL SHALL abort the fill, leaving the words not yet written unchanged, and SHALL NOT produce a fill_done pulse.

Verification
REQ-031 Write 1 to addr 0x2200 with wr_ready=1, then rd_addr=0x2200 -> rd_data=1 exactly 2 cycles after the rd_addr edge; a neighbouring address reads its prior value.
REQ-032 fill_start with fill_value=1 -> busy high for 16384 cycles, wr_ready low throughout, fill_done pulses once; a sweep of all addresses then reads 1.
REQ-033 fill_start and wr_valid in the same IDLE cycle -> write not accepted, fill proceeds; after fill_done, the write is accepted with wr_valid still held.
REQ-034 Write 0 then 1 to the same address while reading it on the same edge -> read returns 0; the next read returns 1.
REQ-035 Fill with value 1, then rst low at busy cycle 100 -> busy 0 and no fill_done; addresses 0..98 read 1, addresses at or above 100 keep their pre-fill value.
REQ-036 fill_start pulsed again mid-fill with the opposite fill_value -> fill length is still 16384 cycles and all words hold the original value.
